// File: rtl/out_fifo_param.sv
// Parametrised output-data FIFO between the PE result path and the writeback drain.
// Define OUT_FIFO_FWFT_EN for first-word-fall-through reads; otherwise DataOut is registered on pop.
module out_fifo_param #(
  parameter int DataWidth       = 32,
  parameter int BufferWidth     = 4,
  parameter int AlmostFullLevel = 12
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      Push,
  input  logic [DataWidth-1:0]      DataIn,
  input  logic                      Pop,
  input  logic                      ClrErr,
  output logic [DataWidth-1:0]      DataOut,
  output logic                      Full,
  output logic                      Empty,
  output logic                      AlmostFull,
  output logic [BufferWidth:0]      Count,
  output logic [2**BufferWidth-1:0] Valid,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int BufferSize = 2**BufferWidth;
  localparam logic [BufferWidth:0] AfLevel = (BufferWidth+1)'(AlmostFullLevel);

  logic [BufferWidth:0]   wPtr_q, wPtr_d;
  logic [BufferWidth:0]   rPtr_q, rPtr_d;
  logic [BufferWidth-1:0] wAddr, rAddr;
  logic [DataWidth-1:0]   mem_q [BufferSize];
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   popAcc, pushAcc;
  logic [BufferWidth-1:0] slotOffset;

  assign wAddr = wPtr_q[BufferWidth-1:0];
  assign rAddr = rPtr_q[BufferWidth-1:0];

  // The pointer MSB is the wrap bit: equal addresses with differing wrap bits means full.
  assign Full       = (wAddr == rAddr) && (wPtr_q[BufferWidth] != rPtr_q[BufferWidth]);
  assign Empty      = (wPtr_q == rPtr_q);
  assign Count      = wPtr_q - rPtr_q;
  assign AlmostFull = (Count >= AfLevel);

  // A push on a full buffer is only legal when the head is leaving in the same cycle.
  assign popAcc  = Pop & ~Empty;
  assign pushAcc = Push & (~Full | popAcc);

  assign wPtr_d = pushAcc ? wPtr_q + (BufferWidth+1)'(1) : wPtr_q;
  assign rPtr_d = popAcc  ? rPtr_q + (BufferWidth+1)'(1) : rPtr_q;

  // A fresh error wins over a simultaneous clear.
  assign overflow_d  = (Push & ~pushAcc) ? 1'b1 : (ClrErr ? 1'b0 : overflow_q);
  assign underflow_d = (Pop & Empty)     ? 1'b1 : (ClrErr ? 1'b0 : underflow_q);

  // Slot i is occupied when its distance past the read address is below the fill count.
  always_comb begin
    Valid      = '0;
    slotOffset = '0;
    for (int i = 0; i < BufferSize; i++) begin
      slotOffset = BufferWidth'(i) - rAddr;
      Valid[i]   = ({1'b0, slotOffset} < Count);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wPtr_q      <= '0;
      rPtr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wPtr_q      <= wPtr_d;
      rPtr_q      <= rPtr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < BufferSize; i++) begin
        mem_q[i] <= '0;
      end
    end else if (pushAcc) begin
      mem_q[wAddr] <= DataIn;
    end
  end

  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

`ifdef OUT_FIFO_FWFT_EN
  assign DataOut = mem_q[rAddr];
`else
  logic [DataWidth-1:0] dataOut_q;

  // Non-blocking read of the head slot sees the old word even when a push-on-full overwrites it.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      dataOut_q <= '0;
    end else if (popAcc) begin
      dataOut_q <= mem_q[rAddr];
    end
  end

  assign DataOut = dataOut_q;
`endif

endmodule

// File: tb/tb_out_fifo_param.sv
// Randomized and directed bench for out_fifo_param against a queue-based reference model.
// Covers both the default instance and a small BufferWidth=2 instance.
module tb_out_fifo_param;

  logic        clk = 1'b0;
  logic        aclr;
  logic        Push, Pop, ClrErr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Full, Empty, AlmostFull, Overflow, Underflow;
  logic [4:0]  Count;
  logic [15:0] Valid;

  logic       push2, pop2, clr2;
  logic [7:0] din2, dout2;
  logic       full2, empty2, af2, ovf2, unf2;
  logic [2:0] cnt2;
  logic [3:0] valid2;

  always #5 clk = ~clk;

  out_fifo_param dut (
    .clk(clk), .aclr(aclr), .Push(Push), .DataIn(DataIn), .Pop(Pop), .ClrErr(ClrErr),
    .DataOut(DataOut), .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull),
    .Count(Count), .Valid(Valid), .Overflow(Overflow), .Underflow(Underflow)
  );

  out_fifo_param #(.DataWidth(8), .BufferWidth(2), .AlmostFullLevel(3)) dutSmall (
    .clk(clk), .aclr(aclr), .Push(push2), .DataIn(din2), .Pop(pop2), .ClrErr(clr2),
    .DataOut(dout2), .Full(full2), .Empty(empty2), .AlmostFull(af2),
    .Count(cnt2), .Valid(valid2), .Overflow(ovf2), .Underflow(unf2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          mOvf, mUnf;
  logic [31:0] mDout;
  int          wrIdx, rdIdx;
  logic [15:0] mMask;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOvf  = 0;
    mUnf  = 0;
    mDout = '0;
    wrIdx = 0;
    rdIdx = 0;
    mMask = '0;
  endtask

  task automatic checkStatus();
    checkOutput("count", 32'(Count), 32'(mq.size()));
    checkOutput("empty", 32'(Empty), 32'(mq.size() == 0));
    checkOutput("full", 32'(Full), 32'(mq.size() == 16));
    checkOutput("almostFull", 32'(AlmostFull), 32'(mq.size() >= 12));
    checkOutput("valid", 32'(Valid), 32'(mMask));
    checkOutput("overflow", 32'(Overflow), 32'(mOvf));
    checkOutput("underflow", 32'(Underflow), 32'(mUnf));
`ifdef OUT_FIFO_FWFT_EN
    if (mq.size() > 0) checkOutput("doutHead", DataOut, mq[0]);
`else
    checkOutput("doutReg", DataOut, mDout);
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic applyStimulus(input bit p, input logic [31:0] d, input bit r, input bit c);
    bit popAcc, pushAcc;
    Push = p; DataIn = d; Pop = r; ClrErr = c;
    #1;
`ifdef OUT_FIFO_FWFT_EN
    if (mq.size() > 0) checkOutput("doutFwft", DataOut, mq[0]);
`endif
    @(posedge clk);
    popAcc  = r && (mq.size() > 0);
    pushAcc = p && ((mq.size() < 16) || popAcc);
    if (p && !pushAcc) mOvf = 1; else if (c) mOvf = 0;
    if (r && !popAcc)  mUnf = 1; else if (c) mUnf = 0;
    if (popAcc) begin
      mDout = mq.pop_front();
      mMask[rdIdx] = 1'b0;
      rdIdx = (rdIdx + 1) % 16;
    end
    if (pushAcc) begin
      mq.push_back(d);
      mMask[wrIdx] = 1'b1;
      wrIdx = (wrIdx + 1) % 16;
    end
    #1;
    checkStatus();
  endtask

  task automatic resetMid();
    Push = 0; Pop = 0; ClrErr = 0;
    #2;
    aclr = 1;
    #1;
    checkOutput("rstCount", 32'(Count), 32'd0);
    checkOutput("rstEmpty", 32'(Empty), 32'd1);
    checkOutput("rstValid", 32'(Valid), 32'd0);
    checkOutput("rstDout", DataOut, 32'd0);
    checkOutput("rstFlags", {30'd0, Overflow, Underflow}, 32'd0);
    modelReset();
    @(negedge clk);
    aclr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic fillSequential();
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'h100 + 32'(i), 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() > 0; i++) applyStimulus(0, 32'h0, 1, 0);
  endtask

  task automatic applyStimulus2(input bit p, input logic [7:0] d, input bit r);
    push2 = p; din2 = d; pop2 = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr = 1; Push = 0; Pop = 0; ClrErr = 0; DataIn = '0;
    push2 = 0; pop2 = 0; clr2 = 0; din2 = '0;
    modelReset();
    #12;
    checkStatus();
    checkOutput("smallRstCount", 32'(cnt2), 32'd0);
    checkOutput("smallRstEmpty", 32'(empty2), 32'd1);
    @(negedge clk);
    aclr = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) applyStimulus(1, $urandom, 0, 0);
    resetMid();
    applyStimulus(0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1);

    fillSequential();
    applyStimulus(1, 32'h1FF, 0, 0);
    drain();
    applyStimulus(0, 32'h0, 0, 1);

    fillSequential();
    applyStimulus(1, 32'hAAAA, 1, 0);
    checkOutput("pushPopFullCount", 32'(Count), 32'd16);
    drain();

    applyStimulus(1, 32'h2000, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1, 32'h2000 + 32'(i), 1, 0);
      checkOutput("wrapOneHot", 32'($countones(Valid)), 32'd1);
    end
    drain();

    fillSequential();
    applyStimulus(1, 32'h1234, 0, 0);
    applyStimulus(0, 32'h0, 0, 1);
    drain();
    applyStimulus(0, 32'h0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) resetMid();
      applyStimulus($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                    $urandom_range(0, 99) < 8);
    end
    Push = 0; Pop = 0; ClrErr = 0;

    for (int k = 1; k <= 4; k++) begin
      applyStimulus2(1, 8'(8'h10 + k), 0);
      checkOutput("smallCount", 32'(cnt2), 32'(k));
      checkOutput("smallFull", 32'(full2), 32'(k == 4));
      checkOutput("smallAlmostFull", 32'(af2), 32'(k >= 3));
      checkOutput("smallValid", 32'(valid2), 32'((1 << k) - 1));
    end
    applyStimulus2(1, 8'hEE, 0);
    checkOutput("smallOverflow", 32'(ovf2), 32'd1);
    checkOutput("smallCountHeld", 32'(cnt2), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      push2 = 0; pop2 = 1;
      #1;
`ifdef OUT_FIFO_FWFT_EN
      checkOutput("smallDoutFwft", 32'(dout2), 32'(8'h10 + k));
`endif
      @(posedge clk);
      #1;
`ifndef OUT_FIFO_FWFT_EN
      checkOutput("smallDoutReg", 32'(dout2), 32'(8'h10 + k));
`endif
      checkOutput("smallDrainCount", 32'(cnt2), 32'(4 - k));
    end
    pop2 = 0;
    checkOutput("smallEmpty", 32'(empty2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
